// File: rtl/icache.sv
// Direct-mapped instruction cache with 16-byte lines and a word-serial refill port.
// Define ICACHE_PERF_CNT_EN to build the saturating hit/miss performance counters.
module icache #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_flag,
  input  logic [31:0] addr,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;
  state_t state_q, state_d;

  logic [31:2]          lat_q;
  logic [1:0]           cnt_q;
  logic                 flush_pending_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES][WORDS_PER_LINE];

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             fill_ack;
  logic             last_ack;
  logic             unused_addr_bits;

  assign off              = lat_q[3:2];
  assign idx              = lat_q[IDX_W+3:4];
  assign tag              = lat_q[31:IDX_W+4];
  assign hit              = valid_q[idx] && (tag_mem[idx] == tag);
  assign fill_ack         = (state_q == REFILL) && mem_ack;
  assign last_ack         = fill_ack && (cnt_q == 2'd3);
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    read_data = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    case (state_q)
      IDLE: if (read_flag) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          done      = 1'b1;
          read_data = data_mem[idx][off];
          state_d   = IDLE;
        end else begin
          busy    = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag, idx, cnt_q, 2'b00};
        if (last_ack) state_d = RESP;
      end
      RESP: begin
        done      = 1'b1;
        read_data = data_mem[idx][off];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush seen at any point of a refill keeps the fresh line invalid and wipes the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= 2'd0;
      flush_pending_q <= 1'b0;
      valid_q         <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LOOKUP && !hit) cnt_q <= 2'd0;
      else if (fill_ack)             cnt_q <= cnt_q + 2'd1;
      if (state_q == REFILL) begin
        if (last_ack) begin
          flush_pending_q <= 1'b0;
          if (flush_pending_q || flush) valid_q      <= '0;
          else                          valid_q[idx] <= 1'b1;
        end else if (flush) begin
          flush_pending_q <= 1'b1;
        end
      end else if (flush) begin
        valid_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && read_flag) lat_q <= addr[31:2];
    if (fill_ack) begin
      data_mem[idx][cnt_q] <= mem_rdata;
      if (cnt_q == 2'd3) tag_mem[idx] <= tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
      else     miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule
